// File: rtl/ram_inout_burst.sv
// Single-port burst RAM on a shared bidirectional data bus.
// Bursts of len+1 words with a wrapping address counter and a bus-turnaround cycle before reads.
module ram_inout_burst #(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH),
  parameter int LW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cs,
  input  logic          wr,
  input  logic          start,
  input  logic [AW-1:0] add,
  input  logic [LW-1:0] len,
  inout  wire  [DW-1:0] data,
  output logic          busy,
  output logic          rd_valid,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, WRITE, TURN, READ} state_t;

  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  state_t        state;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] start_addr;
  logic [LW-1:0] cnt;
  logic [DW-1:0] d_out;
  logic [DW-1:0] mem [DEPTH];

  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] a);
    return (a == LAST) ? '0 : a + 1'b1;
  endfunction

  // add < 2*DEPTH always holds, so one conditional subtract is a full modulo
  always_comb begin
    start_addr = add;
    if ({1'b0, add} >= DEPTH_W) start_addr = add - DEPTH_W[AW-1:0];
  end

  always_ff @(posedge clk) begin
    if (state == WRITE && cs) mem[addr_q] <= data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      addr_q <= '0;
      cnt    <= '0;
      d_out  <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && cs) begin
            addr_q <= start_addr;
            cnt    <= len;
            state  <= wr ? WRITE : TURN;
          end
        end
        WRITE: begin
          if (!cs) begin
            state <= IDLE;
          end else begin
            addr_q <= wrap_inc(addr_q);
            cnt    <= cnt - 1'b1;
            if (cnt == '0) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        TURN: begin
          if (!cs) begin
            state <= IDLE;
          end else begin
            d_out  <= mem[addr_q];
            addr_q <= wrap_inc(addr_q);
            state  <= READ;
          end
        end
        READ: begin
          if (!cs) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            state <= IDLE;
            done  <= 1'b1;
          end else begin
            d_out  <= mem[addr_q];
            addr_q <= wrap_inc(addr_q);
            cnt    <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy     = (state != IDLE);
  // cs gates the driver directly so an abort releases the bus within the cycle
  assign rd_valid = (state == READ) && cs;
  assign data     = rd_valid ? d_out : 'z;

endmodule

// File: tb/tb_ram_inout_burst.sv
// Bench for ram_inout_burst: a DEPTH=16 and a DEPTH=12 instance, a scoreboard of read words
// fed from an array model, and directed plus random bursts.
module tb_ram_inout_burst;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] cs_v = 2'b11, wr_v = '0, start_v = '0;
  logic [3:0] add_v [2];
  logic [3:0] len_v [2];
  logic [1:0] busy_v, rdv_v, done_v;
  logic [1:0] host_en = '0;
  logic [7:0] host_drv [2];
  wire  [7:0] data0, data1;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] mdl [2][16];
  logic [7:0] wbuf [16];
  logic [7:0] exp_q0 [$];
  logic [7:0] exp_q1 [$];

  always #5 clk = ~clk;

  assign data0 = host_en[0] ? host_drv[0] : 'z;
  assign data1 = host_en[1] ? host_drv[1] : 'z;

  ram_inout_burst #(.DW(8), .DEPTH(16), .LW(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .cs(cs_v[0]), .wr(wr_v[0]), .start(start_v[0]),
    .add(add_v[0]), .len(len_v[0]), .data(data0),
    .busy(busy_v[0]), .rd_valid(rdv_v[0]), .done(done_v[0]));

  ram_inout_burst #(.DW(8), .DEPTH(12), .LW(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .cs(cs_v[1]), .wr(wr_v[1]), .start(start_v[1]),
    .add(add_v[1]), .len(len_v[1]), .data(data1),
    .busy(busy_v[1]), .rd_valid(rdv_v[1]), .done(done_v[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int unsigned depth_of(input int unsigned d);
    return (d == 0) ? 16 : 12;
  endfunction

  function automatic int unsigned maddr(input int unsigned d, input int unsigned a, input int unsigned k);
    return ((a % depth_of(d)) + k) % depth_of(d);
  endfunction

  // Read-data monitor: every presented word must be the next one the model predicted.
  always @(negedge clk) begin
    logic [7:0] e;
    if (rdv_v[0]) begin
      if (exp_q0.size() == 0) chk("rd0_unexpected", {24'd0, data0}, 32'hFFFF_FFFF);
      else begin e = exp_q0.pop_front(); chk("rd0_data", {24'd0, data0}, {24'd0, e}); end
    end
    if (rdv_v[1]) begin
      if (exp_q1.size() == 0) chk("rd1_unexpected", {24'd0, data1}, 32'hFFFF_FFFF);
      else begin e = exp_q1.pop_front(); chk("rd1_data", {24'd0, data1}, {24'd0, e}); end
    end
  end

  // All burst tasks are entered and left 1 time unit after a rising edge.
  task automatic do_write(input int unsigned d, input int unsigned a, input int unsigned n,
                          input int unsigned abort_at);
    bit aborted = 0;
    start_v[d] = 1'b1; wr_v[d] = 1'b1; add_v[d] = 4'(a); len_v[d] = 4'(n - 1);
    @(posedge clk); #1;
    start_v[d] = 1'b0;
    chk("wr_busy_start", {31'd0, busy_v[d]}, 1);
    for (int unsigned k = 0; k < n; k++) begin
      if (k == abort_at) begin
        cs_v[d] = 1'b0; host_en[d] = 1'b0; aborted = 1;
        break;
      end
      host_en[d] = 1'b1; host_drv[d] = wbuf[k];
      mdl[d][maddr(d, a, k)] = wbuf[k];
      @(posedge clk); #1;
    end
    host_en[d] = 1'b0;
    if (aborted) begin
      @(posedge clk); #1;
      chk("wr_abort_busy", {31'd0, busy_v[d]}, 0);
      chk("wr_abort_done", {31'd0, done_v[d]}, 0);
      cs_v[d] = 1'b1;
    end else begin
      chk("wr_done", {31'd0, done_v[d]}, 1);
      chk("wr_busy_end", {31'd0, busy_v[d]}, 0);
    end
  endtask

  // kind: 0 = complete, 1 = cs abort at word j, 2 = reset at word j
  task automatic do_read(input int unsigned d, input int unsigned a, input int unsigned n,
                         input int unsigned kind, input int unsigned j, input bit intrude);
    int unsigned seen = (kind != 0) ? j : n;
    for (int unsigned k = 0; k < seen; k++) begin
      if (d == 0) exp_q0.push_back(mdl[0][maddr(0, a, k)]);
      else        exp_q1.push_back(mdl[1][maddr(1, a, k)]);
    end
    start_v[d] = 1'b1; wr_v[d] = 1'b0; add_v[d] = 4'(a); len_v[d] = 4'(n - 1);
    @(posedge clk); #1;
    start_v[d] = 1'b0;
    chk("rd_busy_turn", {31'd0, busy_v[d]}, 1);
    chk("rd_valid_turn", {31'd0, rdv_v[d]}, 0);
    for (int unsigned k = 0; k < n; k++) begin
      @(posedge clk); #1;
      start_v[d] = 1'b0;
      if (kind == 1 && k == j) begin
        cs_v[d] = 1'b0; #1;
        chk("rd_abort_valid", {31'd0, rdv_v[d]}, 0);
        chk("rd_abort_busy_hold", {31'd0, busy_v[d]}, 1);
        @(posedge clk); #1;
        chk("rd_abort_busy", {31'd0, busy_v[d]}, 0);
        chk("rd_abort_done", {31'd0, done_v[d]}, 0);
        cs_v[d] = 1'b1;
        return;
      end
      if (kind == 2 && k == j) begin
        rst_n = 1'b0; #1;
        chk("rst_busy", {31'd0, busy_v[d]}, 0);
        chk("rst_valid", {31'd0, rdv_v[d]}, 0);
        chk("rst_done", {31'd0, done_v[d]}, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        return;
      end
      if (intrude && k == 0) begin
        start_v[d] = 1'b1; wr_v[d] = 1'b1; add_v[d] = 4'(a + 5);
      end
    end
    @(posedge clk); #1;
    chk("rd_done", {31'd0, done_v[d]}, 1);
    chk("rd_busy_end", {31'd0, busy_v[d]}, 0);
    chk("rd_valid_end", {31'd0, rdv_v[d]}, 0);
  endtask

  task automatic fill_rand(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) wbuf[k] = 8'($urandom);
  endtask

  initial begin
    add_v[0] = '0; add_v[1] = '0; len_v[0] = '0; len_v[1] = '0;
    host_drv[0] = '0; host_drv[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int unsigned d = 0; d < 2; d++) begin
      chk("reset_busy", {31'd0, busy_v[d]}, 0);
      chk("reset_valid", {31'd0, rdv_v[d]}, 0);
      chk("reset_done", {31'd0, done_v[d]}, 0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int unsigned d = 0; d < 2; d++) begin
      fill_rand(depth_of(d));
      do_write(d, 0, depth_of(d), 99);
    end

    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'h44;
    do_write(0, 3, 4, 99);
    do_read(0, 3, 4, 0, 0, 0);

    wbuf[0] = 8'hA0; wbuf[1] = 8'hA1; wbuf[2] = 8'hA2; wbuf[3] = 8'hA3;
    do_write(0, 14, 4, 99);
    do_read(0, 14, 1, 0, 0, 0);
    do_read(0, 15, 1, 0, 0, 0);
    do_read(0, 0, 1, 0, 0, 0);
    do_read(0, 1, 1, 0, 0, 0);
    do_write(1, 10, 4, 99);
    do_read(1, 10, 1, 0, 0, 0);
    do_read(1, 11, 1, 0, 0, 0);
    do_read(1, 0, 1, 0, 0, 0);
    do_read(1, 1, 1, 0, 0, 0);

    fill_rand(4);
    do_write(0, 5, 4, 1);
    do_read(0, 5, 4, 0, 0, 0);

    do_read(0, 2, 4, 1, 2, 0);
    do_read(0, 3, 4, 0, 0, 1);

    do_read(0, 0, 6, 2, 2, 0);
    do_read(0, 0, 16, 0, 0, 0);
    do_read(1, 0, 12, 0, 0, 0);

    fill_rand(2);
    do_write(1, 13, 2, 99);
    do_read(1, 1, 2, 0, 0, 0);

    for (int unsigned i = 0; i < 60; i++) begin
      int unsigned d = $urandom_range(0, 1);
      int unsigned a = $urandom_range(0, 15);
      int unsigned n = $urandom_range(1, 16);
      if ($urandom_range(0, 1) == 1) begin
        fill_rand(n);
        do_write(d, a, n, 99);
      end else begin
        do_read(d, a, n, 0, 0, 0);
      end
    end

    repeat (3) @(posedge clk);
    #1;
    chk("q0_drained", exp_q0.size(), 0);
    chk("q1_drained", exp_q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    n_err++;
    $display("FAIL timeout: simulation did not complete, expected to finish before 1000000");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
